// File: rtl/v74x139_pkg.sv
// ============================================================================
// Module      : v74x139_pkg
// Description : Shared types for the v74x139 scan controller (state encoding,
//               digit index type, digit count).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package v74x139_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = 2;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BLANK = 2'b01,
    ST_SHOW  = 2'b10
  } state_e;

endpackage : v74x139_pkg

`default_nettype wire

// File: rtl/v74x139_scan_ctrl_if.sv
// ============================================================================
// Module      : v74x139_scan_ctrl_if
// Description : Control inputs and decoder-drive outputs of the scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface v74x139_scan_ctrl_if;

  logic       run;
  logic [3:0] digit_en;
  logic       g_l;
  logic       a;
  logic       b;
  logic       frame;

  modport master (
    output run,
    output digit_en,
    input  g_l,
    input  a,
    input  b,
    input  frame
  );

  modport slave (
    input  run,
    input  digit_en,
    output g_l,
    output a,
    output b,
    output frame
  );

endinterface : v74x139_scan_ctrl_if

`default_nettype wire

// File: rtl/v74x139_next_digit.sv
// ============================================================================
// Module      : v74x139_next_digit
// Description : Combinational search for the next enabled digit after cur,
//               with a wrap flag when the result is not above cur.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module v74x139_next_digit
  import v74x139_pkg::*;
(
  input  idx_t                  cur,
  input  logic [NUM_DIGITS-1:0] en,
  output idx_t                  nxt,
  output logic                  wrap
);

  idx_t cand;
  logic found;

  // Searches cur+1, cur+2, ... cur+4 (mod 4); the last candidate is cur itself.
  always_comb begin
    nxt   = cur;
    cand  = cur;
    found = 1'b0;
    for (int k = 1; k <= NUM_DIGITS; k++) begin
      cand = cur + idx_t'(k);
      if (!found && en[cand]) begin
        nxt   = cand;
        found = 1'b1;
      end
    end
    wrap = (nxt <= cur);
  end

endmodule : v74x139_next_digit

`default_nettype wire

// File: rtl/v74x139_scan_ctrl.sv
// ============================================================================
// Module      : v74x139_scan_ctrl
// Description : Drives G_L/A/B of a 74x139 to scan up to four digits, with a
//               blanking gap before every digit so A/B never move while enabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module v74x139_scan_ctrl
  import v74x139_pkg::*;
#(
  parameter int PRESCALE  = 1000,
  parameter int BLANK_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  v74x139_scan_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] C_BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] C_SHOW_LAST  = CNT_W'(PRESCALE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  idx_t             idx_q,   idx_d;
  logic             g_l_q,   g_l_d;
  logic             frame_q, frame_d;

  idx_t             search_cur;
  idx_t             nxt_idx;
  logic             nxt_wrap;
  logic             en_any;

  assign en_any = |bus.digit_en;

  // From IDLE, searching after index 3 yields the lowest enabled digit.
  assign search_cur = (state_q == ST_IDLE) ? idx_t'(NUM_DIGITS - 1) : idx_q;

  v74x139_next_digit u_next_digit (
    .cur  (search_cur),
    .en   (bus.digit_en),
    .nxt  (nxt_idx),
    .wrap (nxt_wrap)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    frame_d = 1'b0;

    if (!bus.run || !en_any) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          idx_d   = nxt_idx;
          cnt_d   = '0;
          state_d = ST_BLANK;
        end
        ST_BLANK: begin
          if (cnt_q == C_BLANK_LAST) begin
            cnt_d   = '0;
            state_d = ST_SHOW;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_q == C_SHOW_LAST) begin
            cnt_d   = '0;
            idx_d   = nxt_idx;
            frame_d = nxt_wrap;
            state_d = ST_BLANK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end

    // Registered enable tracks the next state, so G_L is low exactly in SHOW.
    g_l_d = (state_d != ST_SHOW);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      g_l_q   <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      g_l_q   <= g_l_d;
      frame_q <= frame_d;
    end
  end

  assign bus.g_l   = g_l_q;
  assign bus.a     = idx_q[0];
  assign bus.b     = idx_q[1];
  assign bus.frame = frame_q;

endmodule : v74x139_scan_ctrl

`default_nettype wire

// File: tb/tb_v74x139_scan_ctrl.sv
// ============================================================================
// Module      : tb_v74x139_scan_ctrl
// Description : Self-checking bench: period-position model for two parameter
//               sets plus directed literal checks on the PRESCALE=4 instance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_v74x139_scan_ctrl;

  localparam int PS0 = 4;
  localparam int BL0 = 1;
  localparam int PS1 = 1;
  localparam int BL1 = 3;

  logic       clk;
  logic       rst;
  logic       run;
  logic [3:0] en;

  int checks = 0;
  int errors = 0;

  v74x139_scan_ctrl_if bus0 ();
  v74x139_scan_ctrl_if bus1 ();

  assign bus0.run      = run;
  assign bus0.digit_en = en;
  assign bus1.run      = run;
  assign bus1.digit_en = en;

  v74x139_scan_ctrl #(.PRESCALE(PS0), .BLANK_CYC(BL0), .CNT_W(16)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  v74x139_scan_ctrl #(.PRESCALE(PS1), .BLANK_CYC(BL1), .CNT_W(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per instance, running flag, current digit and position within
  // the BLANK+PRESCALE period of that digit.
  int ps_a [2];
  int bl_a [2];
  int m_run[2];
  int m_cur[2];
  int m_t  [2];
  bit m_g  [2];
  bit m_f  [2];

  initial begin
    ps_a[0] = PS0; bl_a[0] = BL0;
    ps_a[1] = PS1; bl_a[1] = BL1;
  end

  function automatic int lowest_en(input logic [3:0] e);
    for (int i = 0; i < 4; i++)
      if (e[i]) return i;
    return 0;
  endfunction

  function automatic int next_en(input int cur, input logic [3:0] e, output bit wrap);
    for (int k = 1; k <= 4; k++) begin
      if (e[(cur + k) % 4]) begin
        wrap = ((cur + k) % 4) <= cur;
        return (cur + k) % 4;
      end
    end
    wrap = 1'b1;
    return cur;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_run[d] = 0; m_cur[d] = 0; m_t[d] = 0; m_g[d] = 1'b1; m_f[d] = 1'b0;
      end else if (!run || en == 4'b0000) begin
        m_run[d] = 0; m_t[d] = 0; m_g[d] = 1'b1; m_f[d] = 1'b0;
      end else if (m_run[d] == 0) begin
        m_run[d] = 1; m_cur[d] = lowest_en(en); m_t[d] = 0;
        m_g[d] = 1'b1; m_f[d] = 1'b0;
      end else begin
        bit w;
        m_t[d] = m_t[d] + 1;
        m_f[d] = 1'b0;
        if (m_t[d] == bl_a[d] + ps_a[d]) begin
          m_t[d]   = 0;
          m_cur[d] = next_en(m_cur[d], en, w);
          m_f[d]   = w;
        end
        m_g[d] = (m_t[d] < bl_a[d]);
      end
    end
  end

  logic [3:0] got[2];
  assign got[0] = {bus0.g_l, bus0.b, bus0.a, bus0.frame};
  assign got[1] = {bus1.g_l, bus1.b, bus1.a, bus1.frame};

  bit       prev_g  [2] = '{1'b1, 1'b1};
  bit [1:0] prev_idx[2] = '{2'd0, 2'd0};
  int       lowcnt  [2] = '{0, 0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [3:0] exp_v;
      exp_v = {m_g[d], 2'(m_cur[d]), m_f[d]};
      checks++;
      if (got[d] !== exp_v) begin
        errors++;
        $display("FAIL model_cmp dut%0d t=%0t: got {g_l,b,a,frame}=%b expected %b",
                 d, $time, got[d], exp_v);
      end
      // A/B must be frozen across any edge with G_L low on both sides.
      if (prev_g[d] == 1'b0 && got[d][3] == 1'b0) begin
        checks++;
        if (got[d][2:1] !== prev_idx[d]) begin
          errors++;
          $display("FAIL ab_stable dut%0d t=%0t: idx moved %0d -> %0d while G_L low",
                   d, $time, prev_idx[d], got[d][2:1]);
        end
      end
      if (got[d][3] == 1'b0) lowcnt[d]++;
      else begin
        if (prev_g[d] == 1'b0 && m_run[d] != 0) begin
          checks++;
          if (lowcnt[d] != ps_a[d]) begin
            errors++;
            $display("FAIL low_len dut%0d t=%0t: G_L low for %0d clocks, expected %0d",
                     d, $time, lowcnt[d], ps_a[d]);
          end
        end
        lowcnt[d] = 0;
      end
      prev_g[d]   = got[d][3];
      prev_idx[d] = got[d][2:1];
    end
  end

  bit       s_g  [1:64];
  bit [1:0] s_idx[1:64];
  bit       s_f  [1:64];

  task automatic run_rec(input int n);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      s_g[i]   = bus0.g_l;
      s_idx[i] = {bus0.b, bus0.a};
      s_f[i]   = bus0.frame;
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] e);
    #1;
    run = r;
    en  = e;
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic go_idle();
    drive(1'b0, en);
    run_rec(2);
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b1;
    en  = 4'b1111;

    // Reset held with RUN=1
    run_rec(3);
    check("rst_g_l",   s_g[3],   1);
    check("rst_idx",   s_idx[3], 0);
    check("rst_frame", s_f[3],   0);
    #1 rst = 1'b0;
    run = 1'b0;
    run_rec(1);
    check("rel_g_l", s_g[1], 1);

    // Full scan
    drive(1'b1, 4'b1111);
    run_rec(45);
    check("full_idx1",  s_idx[1],  0);
    check("full_idx6",  s_idx[6],  1);
    check("full_idx11", s_idx[11], 2);
    check("full_idx16", s_idx[16], 3);
    check("full_idx21", s_idx[21], 0);
    check("full_g1",    s_g[1],    1);
    check("full_g2",    s_g[2],    0);
    check("full_g5",    s_g[5],    0);
    check("full_g6",    s_g[6],    1);
    check("full_f20",   s_f[20],   0);
    check("full_f21",   s_f[21],   1);
    check("full_f41",   s_f[41],   1);
    go_idle();

    // Skip mask
    drive(1'b1, 4'b1010);
    run_rec(16);
    check("skip_idx1",  s_idx[1],  1);
    check("skip_idx6",  s_idx[6],  3);
    check("skip_idx11", s_idx[11], 1);
    check("skip_f6",    s_f[6],    0);
    check("skip_f11",   s_f[11],   1);
    go_idle();

    // Single digit
    drive(1'b1, 4'b0100);
    run_rec(16);
    check("one_idx1", s_idx[1], 2);
    check("one_idx9", s_idx[9], 2);
    check("one_f6",   s_f[6],   1);
    check("one_f7",   s_f[7],   0);
    check("one_f11",  s_f[11],  1);
    check("one_g6",   s_g[6],   1);
    check("one_g7",   s_g[7],   0);
    check("one_g10",  s_g[10],  0);
    go_idle();

    // Stop during SHOW of digit 1, then DIGIT_EN=0 during BLANK
    drive(1'b1, 4'b1111);
    run_rec(8);
    check("stop_pre_g",   s_g[8],   0);
    check("stop_pre_idx", s_idx[8], 1);
    drive(1'b0, 4'b1111);
    run_rec(1);
    check("stop_g",   s_g[1],   1);
    check("stop_idx", s_idx[1], 1);
    drive(1'b1, 4'b1111);
    run_rec(1);
    check("restart_idx", s_idx[1], 0);
    drive(1'b1, 4'b0000);
    run_rec(2);
    check("en0_g", s_g[2], 1);
    drive(1'b1, 4'b0110);
    run_rec(2);
    check("reen_idx", s_idx[1], 1);
    check("reen_g1",  s_g[1],   1);
    check("reen_g2",  s_g[2],   0);

    // Asynchronous reset while SHOW
    run_rec(2);
    #2 rst = 1'b1;
    #1;
    check("arst_g_l", bus0.g_l, 1);
    check("arst_idx", {bus0.b, bus0.a}, 0);
    run_rec(2);
    #1 rst = 1'b0;
    drive(1'b1, 4'b1000);
    run_rec(12);
    check("post_rst_idx", s_idx[1], 3);
    check("post_rst_g2",  s_g[2],   0);
    check("post_rst_f6",  s_f[6],   1);
    go_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule : tb_v74x139_scan_ctrl

`default_nettype wire
